// File: rtl/pipelined_booth_csa_tree.sv
// pipelined_booth_csa_tree
// Radix-4 Booth recoding of two signed WIDTH-bit operands, followed by a
// linear chain of 3:2 carry-save levels that leaves two 2*WIDTH-bit rows
// whose modular sum is the product. A pipeline register bank sits after
// every REG_EVERY levels, and each bank has a bubble-collapsing valid/ready
// handshake.
// Optional feature macro: PIPELINED_BOOTH_CSA_FINAL_ADD_EN adds one more
// stage that carry-propagate adds the two rows (out_carry then reads 0).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (in_valid & in_ready at the input, out_valid & out_ready at the
// output). Stage s advances when it is empty or the stage after it advances.
// The last stage advances when the consumer is ready or the stage is empty.
// in_ready is the advance signal of the first stage. While out_valid is high
// and out_ready is low, every output holds its value.
module pipelined_booth_csa_tree #(
    parameter int WIDTH     = 8,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_sum,
    output logic [2*WIDTH-1:0] out_carry,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = WIDTH / 2;
    localparam int L    = NPP - 1;
    localparam int NROW = NPP + 1;
    localparam int S    = (L + REG_EVERY - 1) / REG_EVERY;
`ifdef PIPELINED_BOOTH_CSA_FINAL_ADD_EN
    localparam int NST  = S + 1;
`else
    localparam int NST  = S;
`endif

    // Booth rows: rows 0..NPP-1 are the partial products, and row NPP holds
    // the +1 corrections for the negative digits.
    logic [PW-1:0] booth_rows [NROW];

    // Per-stage pipeline state. The rows that have not been consumed yet
    // travel with each operation, so later stages never repeat the Booth
    // mux.
    logic [NST-1:0] valid_q, valid_d;
    logic [NST-1:0] adv;
    logic [PW-1:0]    sum_q   [NST];
    logic [PW-1:0]    sum_d   [NST];
    logic [PW-1:0]    carry_q [NST];
    logic [PW-1:0]    carry_d [NST];
    logic [TAG_W-1:0] tag_q   [NST];
    logic [TAG_W-1:0] tag_d   [NST];
    logic [PW-1:0]    rows_q  [NST][NROW];
    logic [PW-1:0]    rows_d  [NST][NROW];

    // Radix-4 Booth recoding of in_b and selection of the partial products.
    always_comb begin
        logic [WIDTH:0] b_ext;
        logic [PW-1:0]  a_ext;
        logic [PW-1:0]  mag;
        logic [PW-1:0]  corr;
        logic           b_hi, b_mid, b_lo;
        logic           one, two, neg;
        b_ext = {in_b, 1'b0};
        a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        corr  = '0;
        mag   = '0;
        b_hi  = 1'b0;
        b_mid = 1'b0;
        b_lo  = 1'b0;
        one   = 1'b0;
        two   = 1'b0;
        neg   = 1'b0;
        for (int j = 0; j < NPP; j++) begin
            b_hi  = b_ext[2*j+2];
            b_mid = b_ext[2*j+1];
            b_lo  = b_ext[2*j];
            one   = b_mid ^ b_lo;
            two   = (b_hi & ~b_mid & ~b_lo) | (~b_hi & b_mid & b_lo);
            // Digit 111 is zero, so it is treated as positive and needs no correction.
            neg   = b_hi & ~(b_mid & b_lo);
            mag   = one ? a_ext : (two ? (a_ext << 1) : '0);
            // The complement is taken before the shift, so the +1 lands at column 2j.
            booth_rows[j] = (neg ? ~mag : mag) << (2 * j);
            corr[2*j]     = neg;
        end
        booth_rows[NPP] = corr;
    end

    // Advance chain, from the consumer back to the input.
    always_comb begin
        adv[NST-1] = out_ready | ~valid_q[NST-1];
        for (int s = NST - 2; s >= 0; s--) begin
            adv[s] = ~valid_q[s] | adv[s+1];
        end
    end

    // Per-stage datapath: the CSA levels for each stage, then load or hold.
    always_comb begin
        logic [PW-1:0]    cs, cc, r, t;
        logic             up_v;
        logic [TAG_W-1:0] up_tag;
        logic [PW-1:0]    up_rows [NROW];
        int               prev;
        cs     = '0;
        cc     = '0;
        r      = '0;
        t      = '0;
        up_v   = 1'b0;
        up_tag = '0;
        prev   = 0;
        for (int i = 0; i < NROW; i++) begin
            up_rows[i] = '0;
        end
        for (int s = 0; s < NST; s++) begin
            prev = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                cs      = booth_rows[0];
                cc      = booth_rows[1];
                up_rows = booth_rows;
                up_v    = in_valid;
                up_tag  = in_tag;
            end else begin
                cs      = sum_q[prev];
                cc      = carry_q[prev];
                up_rows = rows_q[prev];
                up_v    = valid_q[prev];
                up_tag  = tag_q[prev];
            end
            for (int k = 1; k <= L; k++) begin
                if (k > s * REG_EVERY && k <= (s + 1) * REG_EVERY) begin
                    // Level k takes partial product k+1; the last level takes the correction row.
                    r  = (k < L) ? up_rows[k+1] : up_rows[NPP];
                    t  = cs ^ cc ^ r;
                    cc = ((cs & cc) | (cs & r) | (cc & r)) << 1;
                    cs = t;
                end
            end
`ifdef PIPELINED_BOOTH_CSA_FINAL_ADD_EN
            if (s == S) begin
                cs = cs + cc;
                cc = '0;
            end
`endif
            if (adv[s]) begin
                valid_d[s] = up_v;
                sum_d[s]   = cs;
                carry_d[s] = cc;
                tag_d[s]   = up_tag;
                rows_d[s]  = up_rows;
            end else begin
                valid_d[s] = valid_q[s];
                sum_d[s]   = sum_q[s];
                carry_d[s] = carry_q[s];
                tag_d[s]   = tag_q[s];
                rows_d[s]  = rows_q[s];
            end
        end
    end

    // Pipeline registers; reset empties every stage and zeroes its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < NST; s++) begin
                sum_q[s]   <= '0;
                carry_q[s] <= '0;
                tag_q[s]   <= '0;
                for (int i = 0; i < NROW; i++) begin
                    rows_q[s][i] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < NST; s++) begin
                sum_q[s]   <= sum_d[s];
                carry_q[s] <= carry_d[s];
                tag_q[s]   <= tag_d[s];
                for (int i = 0; i < NROW; i++) begin
                    rows_q[s][i] <= rows_d[s][i];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[NST-1];
    assign out_sum   = sum_q[NST-1];
    assign out_carry = carry_q[NST-1];
    assign out_tag   = tag_q[NST-1];

endmodule

// File: tb/tb_pipelined_booth_csa_tree.sv
// Bench for pipelined_booth_csa_tree: an 8-bit / REG_EVERY=1 instance for
// the main checks, and a 16-bit / REG_EVERY=2 instance for the wide corner
// and its latency.
module tb_pipelined_booth_csa_tree;

`ifdef PIPELINED_BOOTH_CSA_FINAL_ADD_EN
    localparam int LAT   = 4;
    localparam int LAT16 = 5;
`else
    localparam int LAT   = 3;
    localparam int LAT16 = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_sum, out_carry;

    logic        v2, rdy2, ov2, ordy2;
    logic [15:0] a2, b2;
    logic [3:0]  tag2, otag2;
    logic [31:0] osum2, ocarry2;

    int n_cmp;
    int n_bad;
    int step_n;
    bit chk_lat;

    logic [15:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];
    int          exp_step_q[$];

    pipelined_booth_csa_tree #(.WIDTH(8), .REG_EVERY(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag)
    );

    pipelined_booth_csa_tree #(.WIDTH(16), .REG_EVERY(2), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .in_tag(tag2),
        .out_valid(ov2), .out_ready(ordy2),
        .out_sum(osum2), .out_carry(ocarry2), .out_tag(otag2)
    );

    // Clock: 10 ns period; the DUT uses the rising edge, and the bench works on falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, got, exp, step_n);
        end
    endtask

    // Reference product: plain signed integer multiply, reduced mod 2^16.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, p;
        pa = int'($signed(a));
        pb = int'($signed(b));
        p  = pa * pb;
        return p[15:0];
    endfunction

    // One cycle: apply inputs, score the handshakes that the next rising edge completes, then move to the next falling edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] t, input logic ordy);
        logic [15:0] got;
        int          acc;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            check("unexpected_output", 64'(exp_q.size() == 0), 64'd0);
            if (exp_q.size() != 0) begin
                got = out_sum + out_carry;
                check("product", 64'(got), 64'(exp_q.pop_front()));
                check("tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
                acc = exp_step_q.pop_front();
                if (chk_lat) check("latency", 64'(step_n - acc), 64'(LAT));
`ifdef PIPELINED_BOOTH_CSA_FINAL_ADD_EN
                check("carry_zero", 64'(out_carry), 64'd0);
`endif
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_prod(a, b));
            exp_tag_q.push_back(t);
            exp_step_q.push_back(step_n);
        end
        @(negedge clk);
        step_n++;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0]  ca [4];
        logic [7:0]  cb [4];
        logic [15:0] hold_sum, hold_carry;
        logic [3:0]  hold_tag;
        bit          held;
        int          k;
        logic [31:0] got32;

        n_cmp = 0;
        n_bad = 0;
        step_n = 0;
        chk_lat = 1'b1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        v2 = 1'b0; a2 = '0; b2 = '0; tag2 = '0; ordy2 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed example: 127 * -1, tag 5
        step(1'b1, 8'd127, 8'hFF, 4'd5, 1'b1);
        drain(20);

        // Corner operands
        ca[0] = 8'h80; cb[0] = 8'h80;
        ca[1] = 8'h80; cb[1] = 8'h7F;
        ca[2] = 8'h00; cb[2] = 8'hB3;
        ca[3] = 8'h7F; cb[3] = 8'h7F;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ca[i], cb[i], 4'(i + 1), 1'b1);
        end
        drain(20);
        check("const_m128_m128", 64'(ref_prod(ca[0], cb[0])), 64'h4000);
        check("const_m128_127", 64'(ref_prod(ca[1], cb[1])), 64'hC080);

        // Streaming: 256 back-to-back random pairs
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drain(20);

        // Backpressure: consumer stalls for 10 cycles
        chk_lat = 1'b0;
        held = 1'b0;
        hold_sum = '0; hold_carry = '0; hold_tag = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0);
            if (out_valid) begin
                if (held) begin
                    check("stall_sum", 64'(out_sum), 64'(hold_sum));
                    check("stall_carry", 64'(out_carry), 64'(hold_carry));
                    check("stall_tag", 64'(out_tag), 64'(hold_tag));
                end
                held = 1'b1;
                hold_sum = out_sum; hold_carry = out_carry; hold_tag = out_tag;
            end
        end
        check("bp_accepted", 64'(exp_q.size()), 64'(LAT));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        drain(20);

        // Full pipeline: accept and drain in the same cycle
        for (int i = 0; i < LAT; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 4'(i), 1'b0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        check("full_accept_drain", 64'(in_ready), 64'd1);
        drain(20);
        chk_lat = 1'b1;

        // Reset mid-flight with two operations in flight
        step(1'b1, 8'h12, 8'h34, 4'd7, 1'b1);
        step(1'b1, 8'hF0, 8'h0F, 4'd8, 1'b1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(out_sum), 64'd0);
        check("mid_rst_carry", 64'(out_carry), 64'd0);
        check("mid_rst_tag", 64'(out_tag), 64'd0);
        exp_q.delete();
        exp_tag_q.delete();
        exp_step_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1);
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        step(1'b1, 8'hC5, 8'h3B, 4'd9, 1'b1);
        drain(20);

        // 16-bit instance, REG_EVERY=2: -32768 * -32768, then one random pair
        for (int p = 0; p < 2; p++) begin
            a2 = (p == 0) ? 16'h8000 : 16'($urandom);
            b2 = (p == 0) ? 16'h8000 : 16'($urandom);
            tag2 = 4'(p + 3);
            v2 = 1'b1;
            #1;
            check("w16_in_ready", 64'(rdy2), 64'd1);
            @(negedge clk);
            v2 = 1'b0;
            k = 1;
            while (!ov2 && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("w16_latency", 64'(k), 64'(LAT16));
            got32 = osum2 + ocarry2;
            check("w16_product", 64'(got32),
                  64'(32'(int'($signed(a2)) * int'($signed(b2)))));
            check("w16_tag", 64'(otag2), 64'(p + 3));
`ifdef PIPELINED_BOOTH_CSA_FINAL_ADD_EN
            check("w16_carry_zero", 64'(ocarry2), 64'd0);
`endif
            @(negedge clk);
        end
        check("w16_const", 64'(32'(int'($signed(16'sh8000)) * int'($signed(16'sh8000)))),
              64'h40000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/pipelined_booth_csa_tree.md
# pipelined_booth_csa_tree

Parametrised, pipelined signed multiplier front end. It radix-4 Booth-encodes two WIDTH-bit two's-complement operands and reduces the partial products through a linear chain of 3:2 carry-save levels to two 2·WIDTH-bit rows. Pipeline registers sit every REG_EVERY levels, and the pipeline uses valid/ready handshakes. It feeds the mantissa product path of the posit FMA unit, where the final carry-propagate add is normally merged with alignment downstream.

## Interface
- WIDTH, default 8: operand width; must be even and ≥4. NPP = WIDTH/2 Booth partial products.
- REG_EVERY, default 1: CSA levels per pipeline stage; range 1..L, where L = NPP−1.
- TAG_W, default 4: width of the sideband tag carried with each operation.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  signed multiplicand.
- in_b  in  WIDTH  signed multiplier, Booth-recoded.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result rows valid.
- out_ready  in  1  consumer accepts.
- out_sum  out  2·WIDTH  sum row.
- out_carry  out  2·WIDTH  carry row; (out_sum+out_carry) mod 2^(2·WIDTH) = in_a·in_b.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Booth stage (combinational at input):
  - Digit j uses in_b bits {2j+1, 2j, 2j−1}, with bit −1 = 0, giving a digit in {−2..+2}.
  - PP_j = digit·in_a, sign-extended to 2·WIDTH and shifted left by 2j.
  - Negative digits use one's complement plus a +1 correction bit at column 2j.
  - All correction bits form one extra row, giving NPP+1 rows in total.
- CSA chain:
  - Level k (k = 1..L) compresses the running {sum, carry} pair with the next row using 3:2 compressors across all 2·WIDTH columns.
  - The correction row enters at the last level.
  - Carry out of column 2·WIDTH−1 is discarded; all arithmetic is mod 2^(2·WIDTH).
- Pipelining:
  - Number of stages S = ceil(L/REG_EVERY).
  - Stage s registers the outputs of levels (s−1)·REG_EVERY+1 .. min(s·REG_EVERY, L).
  - The last stage drives the outputs directly from registers.
  - Each stage holds valid_s, sum, carry and tag.
- Handshake (per stage, bubble-collapsing):
  - adv_S = out_ready | ~valid_S.
  - adv_s = ~valid_s | adv_{s+1}.
  - in_ready = adv_1, which is combinational from out_ready through the valid bits.
  - On adv_s, stage s loads the upstream data, and valid_s ← upstream valid.
  - Otherwise stage s holds its contents.
  - Transfer occurs on in_valid&in_ready, and out_valid&out_ready.
- Stalled outputs: out_sum, out_carry and out_tag are stable while out_valid & ~out_ready.
- Ordering: results emerge in acceptance order; nothing is dropped or duplicated.
- Reset:
  - All valid bits clear asynchronously, and all data registers go to 0.
  - out_valid = 0, out_sum = 0, out_carry = 0, out_tag = 0.
  - in_ready = 1 once reset is released.
  - Reset asserted mid-operation discards all in-flight operations.

## Timing
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+S−1 (S cycles in flight), provided there is no backpressure.
  - Examples: WIDTH=8/REG_EVERY=1 gives S=3; WIDTH=16/REG_EVERY=2 gives S=4.
- Throughput: one operation per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0, and the pipeline holds S operations.
- Simultaneous accept and drain: when the pipeline is full and out_ready = 1, in_ready = 1 in the same cycle.
- Critical path: REG_EVERY CSA levels (plus Booth mux in stage 1), independent of WIDTH except through the fan-in of the adv chain.

## Configuration
- Macro: PIPELINED_BOOTH_CSA_FINAL_ADD_EN.
- Defined:
  - An extra register stage S+1 adds sum+carry with a 2·WIDTH-bit carry-propagate adder.
  - out_sum carries the final product; out_carry is driven 0.
  - Latency is S+1, and the handshake extends with the same adv rule.
- Undefined: two-row output as above, latency S.

## Test plan
- WIDTH=8, REG_EVERY=1, out_ready=1; in_a=127, in_b=−1, tag 5 → after 3 cycles (sum+carry) mod 2^16 = 0xFF81, out_tag=5.
- Corner operands (WIDTH=8):
  - −128 × −128 → 0x4000.
  - −128 × 127 → 0xC080.
  - 0 × −77 → 0x0000.
- Streaming: 256 back-to-back random pairs with out_ready=1 → one result per cycle, in order, all equal to in_a·in_b mod 2^16, with in_ready never low.
- Backpressure:
  - Hold out_ready=0 for 10 cycles while driving in_valid=1 → exactly S operations accepted, in_ready=0 thereafter, outputs stable.
  - Release → results drain in order, with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 2 operations in flight → out_valid=0 and outputs 0 immediately; after release, no stale result appears, and the next accepted pair returns correctly.
- WIDTH=16, REG_EVERY=2, with and without PIPELINED_BOOTH_CSA_FINAL_ADD_EN:
  - in_a=−32768, in_b=−32768 → 0x40000000.
  - Latency is 4 cycles without the macro and 5 with it; with the macro, out_carry=0.
